// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared states, command constants and parity helper for the PS/2 host transmitter
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_DEV,
    SEND,
    ACK,
    RELEASE_WAIT,
    FAIL
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command request/status handshake between a controller and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx_error, rx_inhibit);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx_error, rx_inhibit);
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer with previous-value register and falling-edge detect for one PS/2 line
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic s1, s2, prev;

  // Reset to the idle (released, high) level so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= line;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign fall  = prev & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter driving open-drain pull-down enables
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic              clock,
  input  logic              reset,
  ps2_host_tx_if.slave      bus,
  input  logic              ps2_clk_in,
  input  logic              ps2_dat_in,
  output logic              ps2_clk_pd,
  output logic              ps2_dat_pd
);

  localparam int CNT_MAX = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int XCNT_W  = $clog2(XFER_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [XCNT_W-1:0] XFER_LAST  = XCNT_W'(XFER_TIMEOUT - 1);

  state_t             state, state_n;
  logic [8:0]         shift, shift_n;
  logic [3:0]         bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [XCNT_W-1:0]  xcnt, xcnt_n;
  logic               clk_pd, clk_pd_n, dat_pd, dat_pd_n;
  logic               busy, busy_n, done, done_n, error, error_n;
  logic               clk_level, clk_fall, dat_level, dat_fall;

  ps2_line_sync u_clk_sync (.clock(clock), .reset(reset), .line(ps2_clk_in), .level(clk_level), .fall(clk_fall));
  ps2_line_sync u_dat_sync (.clock(clock), .reset(reset), .line(ps2_dat_in), .level(dat_level), .fall(dat_fall));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      xcnt    <= '0;
      clk_pd  <= 1'b0;
      dat_pd  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      cnt     <= cnt_n;
      xcnt    <= xcnt_n;
      clk_pd  <= clk_pd_n;
      dat_pd  <= dat_pd_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    cnt_n     = cnt;
    xcnt_n    = xcnt;
    clk_pd_n  = clk_pd;
    dat_pd_n  = dat_pd;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = 1'b0;

    if (state inside {SEND, ACK, RELEASE_WAIT}) xcnt_n = xcnt + 1'b1;

    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          shift_n   = {odd_parity(bus.tx_data), bus.tx_data};
          bit_cnt_n = '0;
          cnt_n     = '0;
          clk_pd_n  = 1'b1;
          busy_n    = 1'b1;
          state_n   = INHIBIT;
        end
      end
      // Falls seen here come from our own clock pull-down and are ignored.
      INHIBIT: begin
        if (dat_pd) begin
          clk_pd_n = 1'b0;
          cnt_n    = '0;
          state_n  = WAIT_DEV;
        end else if (cnt == INH_LAST) begin
          dat_pd_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DEV: begin
        if (clk_fall) begin
          dat_pd_n  = ~shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = 4'd1;
          cnt_n     = '0;
          xcnt_n    = '0;
          state_n   = SEND;
        end else if (cnt == START_LAST) begin
          state_n = FAIL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        if (xcnt == XFER_LAST) begin
          state_n = FAIL;
        end else if (clk_fall) begin
          if (bit_cnt < 4'd9) begin
            dat_pd_n  = ~shift[0];
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
          end else begin
            dat_pd_n  = 1'b0;
            bit_cnt_n = 4'd10;
            state_n   = ACK;
          end
        end
      end
      ACK: begin
        if (xcnt == XFER_LAST) state_n = FAIL;
        else if (clk_fall) state_n = dat_level ? FAIL : RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (xcnt == XFER_LAST) begin
          state_n = FAIL;
        end else if (clk_level && dat_level) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      FAIL: begin
        clk_pd_n = 1'b0;
        dat_pd_n = 1'b0;
        error_n  = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.tx_busy    = busy;
  assign bus.rx_inhibit = busy;
  assign bus.tx_done    = done;
  assign bus.tx_error   = error;
  assign ps2_clk_pd     = clk_pd;
  assign ps2_dat_pd     = dat_pd;

endmodule
